// File: rtl/mode_switch_controller.sv
// Mode switch sequencer: debounces the raw mode request, blanks the screens for
// a number of frames, swaps the active mode and holds buttons off until released.
module mode_switch_controller #(
  parameter int SETTLE_CYCLES = 65536,
  parameter int BLANK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] mode_sel,
  input  logic       frame_begin,
  input  logic [4:0] btn_in,
  output logic [1:0] active_mode,
  output logic [4:0] btn_out,
  output logic       blank,
  output logic       mod_reset,
  output logic       busy
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(BLANK_FRAMES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = {SW{1'b1}};
  localparam logic [FW-1:0] FRAME_LAST  = FW'(BLANK_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    BLANK_WAIT,
    BLANK,
    SWITCH,
    RELEASE
  } state_t;

  state_t        state, state_next;
  logic [2:0]    sel_q, sel_prev;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic [1:0]    target, target_next;
  logic [1:0]    active_next;
  logic [1:0]    sel_mode;
  logic          sel_stable;
  logic          gate_btn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      sel_q       <= '0;
      sel_prev    <= '0;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
      target      <= '0;
      active_mode <= '0;
    end else begin
      state       <= state_next;
      sel_q       <= mode_sel;
      sel_prev    <= sel_q;
      settle_cnt  <= settle_next;
      frame_cnt   <= frame_next;
      target      <= target_next;
      active_mode <= active_next;
    end
  end

  // Only one-hot requests select a mode; anything else falls back to home.
  always_comb begin
    case (sel_q)
      3'b001:  sel_mode = 2'b01;
      3'b010:  sel_mode = 2'b10;
      3'b100:  sel_mode = 2'b11;
      default: sel_mode = 2'b00;
    endcase
  end

  assign sel_stable = (sel_q == sel_prev);

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    frame_next  = frame_cnt;
    target_next = target;
    active_next = active_mode;
    case (state)
      IDLE: begin
        if (sel_mode != active_mode) begin
          state_next  = SETTLE;
          settle_next = '0;
        end
      end
      SETTLE: begin
        if (sel_mode == active_mode) begin
          state_next = IDLE;
        end else if (!sel_stable) begin
          settle_next = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          target_next = sel_mode;
          state_next  = BLANK_WAIT;
        end else if (settle_cnt != SETTLE_MAX) begin
          settle_next = settle_cnt + SW'(1);
        end
      end
      BLANK_WAIT: begin
        if (frame_begin) begin
          state_next = BLANK;
          frame_next = '0;
        end
      end
      BLANK: begin
        // Mode is committed on the last pulse so it is already valid during SWITCH.
        if (frame_begin) begin
          if (frame_cnt == FRAME_LAST) begin
            state_next  = SWITCH;
            active_next = target;
          end else begin
            frame_next = frame_cnt + FW'(1);
          end
        end
      end
      SWITCH: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        if (btn_in == 5'b0) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    blank     = 1'b0;
    mod_reset = 1'b0;
    gate_btn  = 1'b0;
    case (state)
      BLANK_WAIT, BLANK: begin
        blank    = 1'b1;
        gate_btn = 1'b1;
      end
      SWITCH: begin
        blank     = 1'b1;
        mod_reset = 1'b1;
        gate_btn  = 1'b1;
      end
      RELEASE: begin
        gate_btn = 1'b1;
      end
      default: begin
        gate_btn = 1'b0;
      end
    endcase
    busy    = (state != IDLE);
    btn_out = (resetn && !gate_btn) ? btn_in : 5'b0;
  end

endmodule

// File: doc/mode_switch_controller.md
MODE_SWITCH_CONTROLLER -- requirements
Module: mode_switch_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 65536: clk cycles mode_sel must hold stable before a switch is accepted.
REQ-002 Parameter BLANK_FRAMES, default 2: number of frame_begin pulses the screens stay blanked before the active mode changes.
REQ-003 Port clk  input  1: system clock; the only clock; all logic on its rising edge.
REQ-004 Port resetn  input  1: reset, asynchronous, active-low.
REQ-005 Port mode_sel  input  3: raw mode request from switch bits 3:1.
REQ-006 Port frame_begin  input  1: one-cycle pulse from the OLED driver, synchronous to clk, at each frame start.
REQ-007 Port btn_in  input  5: debounced buttons {C,U,D,L,R}.
REQ-008 Port active_mode  output  2: current mode: 00 home, 01 basic, 10 graph, 11 game.
REQ-009 Port btn_out  output  5: btn_in gated for the active mode's consumer.
REQ-010 Port blank  output  1: high forces both screens' pixel data to 0.
REQ-011 Port mod_reset  output  1: one-cycle clear pulse to the newly entered mode's module.
REQ-012 Port busy  output  1: high in every FSM state except IDLE.

Function
REQ-013 Decode of mode_sel SHALL be: 000 home, 001 basic, 010 graph, 100 game, any other value home.
REQ-014 FSM states SHALL be IDLE, SETTLE, BLANK_WAIT, BLANK, SWITCH and RELEASE.
REQ-015 IDLE: if decoded target != active_mode, go to SETTLE and clear the settle counter; otherwise stay.
REQ-016 SETTLE: counter increments each cycle while mode_sel is unchanged from the previous cycle.
REQ-017 SETTLE: a mode_sel change restarts the counter at 0.
REQ-018 SETTLE: if the decoded target equals active_mode, return to IDLE with no switch.
REQ-019 SETTLE: when the counter reaches SETTLE_CYCLES-1 with mode_sel stable, latch the target and go to BLANK_WAIT.
REQ-020 BLANK_WAIT: blank high and btn_out forced to 0; on the first frame_begin, go to BLANK with frame count 0.
REQ-021 A frame_begin in the cycle the FSM enters BLANK_WAIT SHALL NOT be counted.
REQ-022 BLANK: blank high and btn_out 0; each frame_begin increments the frame count; on the BLANK_FRAMES-th pulse, go to SWITCH.
REQ-023 SWITCH (exactly 1 cycle): active_mode gets the latched target; mod_reset high this cycle only; blank high; go to RELEASE.
REQ-024 RELEASE: blank low and btn_out 0 until btn_in == 0 for one full cycle, then go to IDLE.
REQ-025 A button held across a switch SHALL never reach the new mode.
REQ-026 In IDLE, btn_out SHALL equal btn_in with zero combinational latency.
REQ-027 Home mode: btn_out SHALL be passed through all the same; the home consumer ignores it.
REQ-028 mode_sel changes during BLANK_WAIT, BLANK, SWITCH or RELEASE SHALL NOT abort the sequence.
REQ-029 After such a change, IDLE re-evaluates on its first cycle and starts a new SETTLE if the target differs.
REQ-030 The settle counter SHALL be wide enough for SETTLE_CYCLES and saturate; it never wraps.
REQ-031 The frame counter SHALL be ceil(log2(BLANK_FRAMES+1)) bits and cleared on entry to BLANK.
REQ-032 mode_sel SHALL be registered once before decode; the latency from a stable change to entering SETTLE is 2 cycles.

Reset
REQ-033 While resetn is low, the block SHALL immediately hold: FSM IDLE, active_mode 00, btn_out 0, blank 0, mod_reset 0, busy 0, all counters 0.
REQ-034 A resetn assertion mid-sequence SHALL abandon the switch.
REQ-035 After release from reset, active_mode SHALL be 00 and the first IDLE cycle re-evaluates mode_sel.
REQ-036 Deassertion of resetn SHALL be synchronised in the parent; this block relies on that.

Verification (SETTLE_CYCLES=4, BLANK_FRAMES=2)
REQ-037 Normal switch: mode_sel 000->001 held, frame_begin every 20 cycles, btn_in 0 -> busy rises; blank high until the 2nd counted frame_begin; one-cycle mod_reset with active_mode=01; back to IDLE one cycle later.
REQ-038 Glitch rejection: mode_sel 000->001 for 2 cycles, then back to 000 -> returns to IDLE; blank and mod_reset never assert; active_mode stays 00.
REQ-039 Held button: btnC held from before the switch until 10 cycles after SWITCH -> btn_out stays 0 throughout; btn_out follows btn_in only after one cycle of btn_in==0 and return to IDLE.
REQ-040 Change during blank: 000->010 settles; mode_sel set to 100 during BLANK -> active_mode becomes 10; then a second full sequence ends with active_mode=11.
REQ-041 Reset mid-sequence: resetn low during BLANK -> same-cycle outputs active_mode=00, blank=0, busy=0; after release with mode_sel=001 a fresh sequence runs.
REQ-042 Coincident pulse: frame_begin coincides with BLANK_WAIT entry -> not counted; blank lasts through two subsequent pulses.
